// File: rtl/m_pw_mem_ctrl.sv
// m_pw_mem_ctrl: memory-side sequencer between the MMU page walker and DRAM.
// Serialises PTE reads (L1, L0), PTE A/D write-backs and buffered CPU
// accesses into single DRAM commands. Page-walk traffic always wins.
// Optional feature macro: PW_MEM_TIMEOUT_EN (abort a stuck DRAM access
// after TIMEOUT_CYC cycles).
module m_pw_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [2:0]  w_pw_state,
    input  logic        w_tlb_acs,
    input  logic [31:0] w_tlb_pte_addr,
    input  logic        w_pte_we,
    input  logic [31:0] w_pte_wdata,
    input  logic        w_cpu_req,
    input  logic        w_cpu_we,
    input  logic [31:0] w_cpu_addr,
    input  logic [31:0] w_cpu_wdata,
    input  logic [2:0]  w_cpu_ctrl,
    output logic        w_mem_busy,
    output logic [31:0] w_mem_odata,
    output logic        w_cpu_done,
    output logic [31:0] o_dram_addr,
    output logic [31:0] o_dram_wdata,
    output logic [2:0]  o_dram_ctrl,
    output logic        o_dram_le,
    output logic        o_dram_we,
    input  logic        i_dram_busy,
    input  logic        i_dram_done,
    input  logic [31:0] i_dram_rdata,
    output logic        w_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic [1:0] {SRC_L1, SRC_L0, SRC_UPD, SRC_CPU} src_t;

    localparam logic [2:0]  CTRL_WORD = 3'b010;
    localparam logic [16:0] TMO_LIM   = 17'(TIMEOUT_CYC);

    state_t      state_q;
    src_t        src_q;
    logic        rd_q;
    logic [31:0] pte_addr_q;
    logic        l1_done_q, l0_done_q, upd_done_q;
    logic        cpu_pend_q, cpu_we_q;
    logic [31:0] cpu_addr_q, cpu_wdata_q;
    logic [2:0]  cpu_ctrl_q;

    logic [31:0] odata_q, addr_q, wdata_q;
    logic [2:0]  ctrl_q;
    logic        le_q, we_q, cpu_done_q, tmo_q;

    logic is_idle, start_l1, start_l0, start_upd, start_cpu;
    logic accept, done_ok, tmo_hit, finish;

    // Start conditions are only meaningful in IDLE; gating with RST_X keeps
    // w_mem_busy at 0 while reset is held.
    assign is_idle   = (state_q == S_IDLE);
    assign start_l1  = RST_X && is_idle && (w_pw_state == 3'd1) && !l1_done_q;
    assign start_l0  = RST_X && is_idle && (w_pw_state == 3'd3) && !l0_done_q;
    assign start_upd = RST_X && is_idle && (w_pw_state == 3'd5) && w_pte_we && !upd_done_q;
    assign start_cpu = RST_X && is_idle && (w_pw_state == 3'd0) && cpu_pend_q;

    assign accept  = (state_q == S_ISSUE) && !i_dram_busy;
    assign done_ok = (state_q == S_WAIT) && i_dram_done;
    assign finish  = done_ok || tmo_hit;

`ifdef PW_MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Cycles spent in ISSUE/WAIT for the current command; restarts in IDLE.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X)       tmo_cnt_q <= '0;
        else if (is_idle) tmo_cnt_q <= '0;
        else              tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end

    // A real completion in the same cycle beats the abort.
    assign tmo_hit = !is_idle && !done_ok && (({1'b0, tmo_cnt_q} + 17'd1) == TMO_LIM);
`else
    // No abort path in this build; TIMEOUT_CYC is referenced but inert.
    assign tmo_hit = 1'b0 && (TMO_LIM != '0);
`endif

    assign w_mem_busy   = !is_idle || start_l1 || start_l0 || start_upd;
    assign w_mem_odata  = odata_q;
    assign w_cpu_done   = cpu_done_q;
    assign o_dram_addr  = addr_q;
    assign o_dram_wdata = wdata_q;
    assign o_dram_ctrl  = ctrl_q;
    assign o_dram_le    = le_q;
    assign o_dram_we    = we_q;
    assign w_timeout    = tmo_q;

    // Capture the PTE address whenever the MMU presents one.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X)         pte_addr_q <= '0;
        else if (w_tlb_acs) pte_addr_q <= w_tlb_pte_addr;
    end

    // Per-walk completion flags: cleared between walks, set on finish.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            l1_done_q  <= 1'b0;
            l0_done_q  <= 1'b0;
            upd_done_q <= 1'b0;
        end else begin
            if (w_pw_state == 3'd0) begin
                l1_done_q  <= 1'b0;
                l0_done_q  <= 1'b0;
                upd_done_q <= 1'b0;
            end
            if (finish) begin
                unique case (src_q)
                    SRC_L1:  l1_done_q  <= 1'b1;
                    SRC_L0:  l0_done_q  <= 1'b1;
                    SRC_UPD: upd_done_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Single-entry CPU buffer; a request while full is dropped.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            cpu_pend_q  <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            cpu_ctrl_q  <= '0;
        end else if (finish && src_q == SRC_CPU) begin
            cpu_pend_q <= 1'b0;
        end else if (w_cpu_req && !cpu_pend_q) begin
            cpu_pend_q  <= 1'b1;
            cpu_we_q    <= w_cpu_we;
            cpu_addr_q  <= w_cpu_addr;
            cpu_wdata_q <= w_cpu_wdata;
            cpu_ctrl_q  <= w_cpu_ctrl;
        end
    end

    // Command sequencer with registered DRAM strobes and result outputs.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_L1;
            rd_q       <= 1'b0;
            odata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ctrl_q     <= '0;
            le_q       <= 1'b0;
            we_q       <= 1'b0;
            cpu_done_q <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            cpu_done_q <= 1'b0;
            tmo_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_l1 || start_l0) begin
                        state_q <= S_ISSUE;
                        src_q   <= start_l1 ? SRC_L1 : SRC_L0;
                        rd_q    <= 1'b1;
                        addr_q  <= pte_addr_q;
                        wdata_q <= '0;
                        ctrl_q  <= CTRL_WORD;
                        le_q    <= 1'b1;
                    end else if (start_upd) begin
                        state_q <= S_ISSUE;
                        src_q   <= SRC_UPD;
                        rd_q    <= 1'b0;
                        addr_q  <= w_tlb_pte_addr;
                        wdata_q <= w_pte_wdata;
                        ctrl_q  <= CTRL_WORD;
                        we_q    <= 1'b1;
                    end else if (start_cpu) begin
                        state_q <= S_ISSUE;
                        src_q   <= SRC_CPU;
                        rd_q    <= !cpu_we_q;
                        addr_q  <= cpu_addr_q;
                        wdata_q <= cpu_wdata_q;
                        ctrl_q  <= cpu_ctrl_q;
                        le_q    <= !cpu_we_q;
                        we_q    <= cpu_we_q;
                    end
                end
                S_ISSUE: begin
                    if (tmo_hit || accept) begin
                        le_q    <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= tmo_hit ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (finish) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Result delivery shared by normal completion and abort.
            if (done_ok && rd_q)                       odata_q <= i_dram_rdata;
            if (tmo_hit && (rd_q || src_q == SRC_CPU)) odata_q <= '0;
            if (finish && src_q == SRC_CPU)            cpu_done_q <= 1'b1;
            if (tmo_hit)                               tmo_q <= 1'b1;
        end
    end

endmodule
